// File: rtl/neuron.sv
// Spiking neuron: asynchronous spike capture, clock-domain synchronisation and a
// saturating signed membrane potential that fires a one-cycle output spike at threshold.
`timescale 1ns/1ps

module neuron (
    input  logic       clk,
    input  logic       rst,
    input  logic       weight,
    input  logic [7:0] threshold,
    input  logic       pos_in,
    input  logic       neg_in,
    output logic       pos_out,
    output logic       neg_out
);

    localparam logic signed [10:0] SAT_MAX = 11'sd511;
    localparam logic signed [10:0] SAT_MIN = -11'sd511;

    logic              pos_tgl_r;
    logic              neg_tgl_r;
    logic [2:0]        pos_sync_r;
    logic [2:0]        neg_sync_r;
    logic              pos_ev_s;
    logic              neg_ev_s;
    logic signed [9:0] potential_r;
    logic signed [9:0] potential_nxt_s;
    logic signed [1:0] contrib_s;
    logic signed [10:0] sum_s;
    logic signed [9:0] next_s;
    logic signed [9:0] thr_s;
    logic              fire_pos_s;
    logic              fire_neg_s;
    logic              pos_out_r;
    logic              neg_out_r;

    // Clamp an 11-bit intermediate sum into the symmetric -511..+511 range
    function automatic logic signed [9:0] sat10(input logic signed [10:0] v);
        logic signed [9:0] r;
        if (v > SAT_MAX) begin
            r = 10'sd511;
        end else if (v < SAT_MIN) begin
            r = -10'sd511;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Toggle on every positive input pulse so arbitrarily narrow pulses are kept
    always_ff @(posedge pos_in or posedge rst) begin
        if (rst) begin
            pos_tgl_r <= 1'b0;
        end else begin
            pos_tgl_r <= ~pos_tgl_r;
        end
    end

    // Toggle on every negative input pulse
    always_ff @(posedge neg_in or posedge rst) begin
        if (rst) begin
            neg_tgl_r <= 1'b0;
        end else begin
            neg_tgl_r <= ~neg_tgl_r;
        end
    end

    // Two synchroniser stages plus one history stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_sync_r <= 3'b000;
            neg_sync_r <= 3'b000;
        end else begin
            pos_sync_r <= {pos_sync_r[1:0], pos_tgl_r};
            neg_sync_r <= {neg_sync_r[1:0], neg_tgl_r};
        end
    end

    assign pos_ev_s = pos_sync_r[2] ^ pos_sync_r[1];
    assign neg_ev_s = neg_sync_r[2] ^ neg_sync_r[1];

    // Event contribution, saturated next value and threshold comparison
    always_comb begin
        contrib_s       = 2'sb00;
        fire_pos_s      = 1'b0;
        fire_neg_s      = 1'b0;
        potential_nxt_s = potential_r;
        case ({pos_ev_s, neg_ev_s})
            2'b10:   contrib_s = weight ? -2'sd1 : 2'sd1;
            2'b01:   contrib_s = weight ? 2'sd1 : -2'sd1;
            default: contrib_s = 2'sb00;
        endcase
        sum_s  = {potential_r[9], potential_r} + {{9{contrib_s[1]}}, contrib_s};
        next_s = sat10(sum_s);
        if (threshold == 8'd0) begin
            thr_s = 10'sd1;
        end else begin
            thr_s = $signed({2'b00, threshold});
        end
        // Only a net-nonzero event may move the potential or fire
        if (contrib_s != 2'sb00) begin
            if (next_s >= thr_s) begin
                fire_pos_s      = 1'b1;
                potential_nxt_s = 10'sd0;
            end else if (next_s <= -thr_s) begin
                fire_neg_s      = 1'b1;
                potential_nxt_s = 10'sd0;
            end else begin
                potential_nxt_s = next_s;
            end
        end else begin
            potential_nxt_s = potential_r;
        end
    end

    // Membrane potential and registered output spikes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            potential_r <= 10'sd0;
            pos_out_r   <= 1'b0;
            neg_out_r   <= 1'b0;
        end else begin
            potential_r <= potential_nxt_s;
            pos_out_r   <= fire_pos_s;
            neg_out_r   <= fire_neg_s;
        end
    end

    assign pos_out = pos_out_r;
    assign neg_out = neg_out_r;

endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: scripted scenarios plus random spike traffic
// compared against an integer reference model of the membrane.
`timescale 1ns/1ps

module tb_neuron;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       weight = 1'b0;
    logic [7:0] threshold = 8'd2;
    logic       pos_in = 1'b0;
    logic       neg_in = 1'b0;
    logic       pos_out;
    logic       neg_out;

    int n_cmp = 0;
    int n_bad = 0;
    int pos_cnt = 0;
    int neg_cnt = 0;
    int both_cnt = 0;
    int m_pot = 0;
    int m_pos = 0;
    int m_neg = 0;

    neuron dut (
        .clk       (clk),
        .rst       (rst),
        .weight    (weight),
        .threshold (threshold),
        .pos_in    (pos_in),
        .neg_in    (neg_in),
        .pos_out   (pos_out),
        .neg_out   (neg_out)
    );

    always #1.5 clk = ~clk;

    // Count output cycles; each firing must contribute exactly one
    always @(negedge clk) begin
        if (pos_out === 1'b1) pos_cnt++;
        if (neg_out === 1'b1) neg_cnt++;
        if (pos_out === 1'b1 && neg_out === 1'b1) both_cnt++;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer potential, arithmetic straight from the firing rules
    task automatic model_step(input bit p, input bit n);
        int c;
        int nx;
        int t;
        c = (int'(p) - int'(n)) * (weight ? -1 : 1);
        if (c == 0) return;
        nx = m_pot + c;
        if (nx > 511) nx = 511;
        if (nx < -511) nx = -511;
        t = (threshold == 8'd0) ? 1 : int'(threshold);
        if (nx >= t) begin
            m_pos++;
            m_pot = 0;
        end else if (nx <= -t) begin
            m_neg++;
            m_pot = 0;
        end else begin
            m_pot = nx;
        end
    endtask

    task automatic pulse(input bit p, input bit n);
        @(negedge clk);
        #(0.1 * $urandom_range(0, 14));
        pos_in = p;
        neg_in = n;
        #1.0;
        pos_in = 1'b0;
        neg_in = 1'b0;
    endtask

    task automatic do_spike(input bit p, input bit n);
        int pot_before;
        pot_before = m_pot;
        pulse(p, n);
        model_step(p, n);
        @(posedge clk);
        @(negedge clk);
        #0.2;
        check_val("early_hold", dut.potential_r, pot_before);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #0.2;
        check_val("pos_out_cnt", pos_cnt, m_pos);
        check_val("neg_out_cnt", neg_cnt, m_neg);
        check_val("potential", dut.potential_r, m_pot);
    endtask

    initial begin
        int found;
        #2.0;
        check_val("rst_pot", dut.potential_r, 0);
        check_val("rst_pos_out", pos_out, 0);
        check_val("rst_neg_out", neg_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #0.2;
        check_val("no_spurious_pot", dut.potential_r, 0);
        check_val("no_spurious_cnt", pos_cnt + neg_cnt, 0);

        // pos, neg, pos, pos, then neg, pos, pos at threshold 2
        weight = 1'b0; threshold = 8'd2;
        do_spike(1'b1, 1'b0); check_val("seq_pot1", dut.potential_r, 1);
        do_spike(1'b0, 1'b1); check_val("seq_pot0", dut.potential_r, 0);
        do_spike(1'b1, 1'b0);
        do_spike(1'b1, 1'b0); check_val("seq_fire", pos_cnt, 1);
        do_spike(1'b0, 1'b1); check_val("seq_potm1", dut.potential_r, -1);
        do_spike(1'b1, 1'b0);
        do_spike(1'b1, 1'b0); check_val("seq_pot1b", dut.potential_r, 1);
        do_spike(1'b0, 1'b1);

        // Two negatives fire neg_out
        do_spike(1'b0, 1'b1);
        do_spike(1'b0, 1'b1); check_val("neg_fire", neg_cnt, 1);

        // Inverted weight, threshold 1
        weight = 1'b1; threshold = 8'd1;
        do_spike(1'b1, 1'b0); check_val("inv_fire", neg_cnt, 2);

        // Threshold 0 behaves as 1
        weight = 1'b0; threshold = 8'd0;
        do_spike(1'b1, 1'b0); check_val("thr0_fire", pos_cnt, 2);

        // Simultaneous pos and neg cancel
        threshold = 8'd1;
        do_spike(1'b1, 1'b1);

        // Full-range threshold with 300 spikes
        threshold = 8'd255;
        for (int i = 0; i < 300; i++) do_spike(1'b1, 1'b0);
        check_val("thr255_fires", pos_cnt, 3);

        // Reset mid-accumulation clears without a clock edge
        @(negedge clk);
        #0.3;
        rst = 1'b1;
        #0.2;
        m_pot = 0;
        check_val("async_rst_pot", dut.potential_r, 0);
        check_val("async_rst_pos", pos_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while an output spike is high
        threshold = 8'd1;
        pulse(1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(posedge clk);
            #0.2;
            if (pos_out === 1'b1) found = 1;
        end
        check_val("fire_seen", found, 1);
        rst = 1'b1;
        #0.1;
        check_val("rst_clears_out", pos_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Spike during reset is discarded
        rst = 1'b1;
        pulse(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #0.2;
        check_val("rst_spike_pot", dut.potential_r, 0);
        check_val("rst_spike_cnt", pos_cnt, m_pos);

        // Reset while a spike is still unsynchronised drops it
        @(negedge clk);
        pos_in = 1'b1;
        #0.3;
        pos_in = 1'b0;
        #0.3;
        rst = 1'b1;
        #0.2;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #0.2;
        check_val("pending_drop_pot", dut.potential_r, 0);
        check_val("pending_drop_cnt", pos_cnt, m_pos);
        do_spike(1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            int kind;
            if ($urandom_range(0, 7) == 0) begin
                weight = 1'($urandom_range(0, 1));
                threshold = 8'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 15) == 0) begin
                threshold = 8'd1;
                repeat (5) @(negedge clk);
                #0.2;
                check_val("no_event_hold_pot", dut.potential_r, m_pot);
                check_val("no_event_hold_cnt", pos_cnt + neg_cnt, m_pos + m_neg);
            end
            kind = $urandom_range(0, 4);
            if (kind <= 1) do_spike(1'b1, 1'b0);
            else if (kind <= 3) do_spike(1'b0, 1'b1);
            else do_spike(1'b1, 1'b1);
        end

        check_val("no_overlap", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron.md
NEURON -- requirements
Module: neuron

Interface
REQ-001 clk  input  1  single clock; all state except input capture flops updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-003 weight  input  1  synapse polarity: 0 = direct, 1 = inverted; static or changed only while no spike is pending.
REQ-004 threshold  input  8  unsigned firing magnitude; value 0 SHALL be treated as 1.
REQ-005 pos_in  input  1  positive input spike; asynchronous pulse, min width 1 ns, min spacing 3 clk periods.
REQ-006 neg_in  input  1  negative input spike; same timing rules as pos_in.
REQ-007 pos_out  output  1  positive output spike, registered, one clk cycle wide.
REQ-008 neg_out  output  1  negative output spike, registered, one clk cycle wide.

Function
REQ-009 Each spike input SHALL have a toggle flop clocked by that input's rising edge, so pulses narrower than a clk period are never lost.
REQ-010 Each toggle SHALL pass through a 2-flop synchronizer into clk, then an edge detector producing a 1-cycle event (pos_ev, neg_ev).
REQ-011 Latency from an input rising edge to the membrane update SHALL be 2 to 3 clk rising edges.
REQ-012 Membrane potential SHALL be a signed 10-bit register, range -511..+511, saturating at both limits, never wrapping.
REQ-013 Contribution per event: weight=0: pos_ev +1, neg_ev -1; weight=1: pos_ev -1, neg_ev +1.
REQ-014 pos_ev and neg_ev in the same cycle SHALL net to 0: no change, no firing.
REQ-015 Let next = saturated(potential + contribution); T = max(threshold,1), zero-extended.
REQ-016 If next >= +T: potential <= 0, pos_out <= 1 for exactly that cycle.
REQ-017 Else if next <= -T: potential <= 0, neg_out <= 1 for exactly that cycle.
REQ-018 Otherwise potential <= next; pos_out and neg_out <= 0.
REQ-019 pos_out and neg_out SHALL never be high in the same cycle.
REQ-020 Cycles without events SHALL hold the potential (no leak) and drive both outputs 0.
REQ-021 threshold and weight SHALL be sampled combinationally at the update edge; a threshold lowered below |potential| without an event SHALL NOT fire until the next event.

Reset
REQ-022 rst high SHALL asynchronously clear: potential to 0, pos_out and neg_out to 0, toggle flops, synchronizers and edge detectors to 0.
REQ-023 Spikes arriving while rst is high SHALL be discarded.
REQ-024 After rst falls, the first spike SHALL be processed normally; no spurious event SHALL result from reset release.
REQ-025 Reset during a pending, unsynchronized spike SHALL drop that spike.

Verification
REQ-026 weight=0, threshold=2, 1 ns pulses 11 ns apart: pos, neg, pos, pos -> potential 1, 0, 1, then pos_out one cycle, potential 0.
REQ-027 Continue the REQ-026 sequence with neg, pos, pos -> potential -1, 0, 1; no output spikes.
REQ-028 weight=0, threshold=2: neg, neg -> neg_out one cycle on the second update, potential 0.
REQ-029 weight=1, threshold=1: single pos_in -> neg_out one cycle.
REQ-030 threshold=0: single pos_in (weight=0) -> pos_out (threshold treated as 1).
REQ-031 threshold=255: 300 pos spikes -> pos_out only on the 255th, potential back to 0; assert rst mid-accumulation -> potential 0 and outputs 0 immediately, with no clk edge required.
